// File: rtl/usb_setup_parser.sv
// USB control-endpoint SETUP packet parser: captures 8 bytes on EP0 and commits the fields.
// Optional standard-request decode is enabled by defining USB_SETUP_STDDEC_EN.
module usb_setup_parser (
    input  logic        clk,
    input  logic        rst0_async,
    input  logic        rst0_sync,
    input  logic [1:0]  trsac_type,
    input  logic [3:0]  trsac_ep,
    input  logic [1:0]  trsac_req_in,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  bm_request_type,
    output logic [7:0]  b_request,
    output logic [15:0] w_value,
    output logic [15:0] w_index,
    output logic [15:0] w_length,
    output logic        setup_valid,
    output logic        setup_err,
    output logic        std_setaddr,
    output logic        std_setconf,
    output logic        std_clrhalt
);

    typedef enum logic {IDLE, CAPTURE} state_t;

    localparam logic [1:0] TYPE_SETUP = 2'd0;
    localparam logic [1:0] REQ_OK     = 2'd0;
    localparam logic [1:0] REQ_ACTIVE = 2'd1;
    localparam logic [1:0] REQ_FAIL   = 2'd2;

    state_t      r_state, w_next_state;
    logic [3:0]  r_count, w_cnt_next;
    logic        r_ovf, w_ovf_next;
    logic [7:0]  r_shadow [8];
    logic [7:0]  w_shadow_next [8];
    logic        w_commit, w_err;

    logic [7:0]  r_bm, r_breq;
    logic [15:0] r_wval, r_widx, r_wlen;
    logic        r_setup_valid, r_setup_err;

    always_ff @(posedge clk or negedge rst0_async) begin
        if (!rst0_async)     r_state <= IDLE;
        else if (!rst0_sync) r_state <= IDLE;
        else                 r_state <= w_next_state;
    end

    // A byte arriving together with OK is folded in before the length check,
    // so commit reads from the next-state shadow rather than the registered one.
    always_comb begin
        w_next_state  = r_state;
        w_cnt_next    = r_count;
        w_ovf_next    = r_ovf;
        w_shadow_next = r_shadow;
        w_commit      = 1'b0;
        w_err         = 1'b0;
        case (r_state)
            IDLE: begin
                if (trsac_req_in == REQ_ACTIVE && trsac_type == TYPE_SETUP && trsac_ep == 4'd0) begin
                    w_next_state = CAPTURE;
                    w_cnt_next   = '0;
                    w_ovf_next   = 1'b0;
                end
            end
            CAPTURE: begin
                if (rx_valid) begin
                    if (r_count == 4'd8) begin
                        w_ovf_next = 1'b1;
                    end else begin
                        w_shadow_next[r_count[2:0]] = rx_data;
                        w_cnt_next = r_count + 4'd1;
                    end
                end
                if (trsac_req_in == REQ_OK) begin
                    w_next_state = IDLE;
                    if (w_cnt_next == 4'd8 && !w_ovf_next) w_commit = 1'b1;
                    else                                    w_err    = 1'b1;
                end else if (trsac_req_in == REQ_FAIL) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst0_async) begin
        if (!rst0_async || !rst0_sync) begin
            r_count       <= '0;
            r_ovf         <= 1'b0;
            r_shadow      <= '{default: '0};
            r_bm          <= '0;
            r_breq        <= '0;
            r_wval        <= '0;
            r_widx        <= '0;
            r_wlen        <= '0;
            r_setup_valid <= 1'b0;
            r_setup_err   <= 1'b0;
        end else begin
            r_count       <= w_cnt_next;
            r_ovf         <= w_ovf_next;
            r_shadow      <= w_shadow_next;
            r_setup_valid <= w_commit;
            r_setup_err   <= w_err;
            if (w_commit) begin
                r_bm   <= w_shadow_next[0];
                r_breq <= w_shadow_next[1];
                r_wval <= {w_shadow_next[3], w_shadow_next[2]};
                r_widx <= {w_shadow_next[5], w_shadow_next[4]};
                r_wlen <= {w_shadow_next[7], w_shadow_next[6]};
            end
        end
    end

`ifdef USB_SETUP_STDDEC_EN
    logic r_std_setaddr, r_std_setconf, r_std_clrhalt;

    always_ff @(posedge clk or negedge rst0_async) begin
        if (!rst0_async || !rst0_sync) begin
            r_std_setaddr <= 1'b0;
            r_std_setconf <= 1'b0;
            r_std_clrhalt <= 1'b0;
        end else if (w_commit) begin
            r_std_setaddr <= (w_shadow_next[0] == 8'h00) && (w_shadow_next[1] == 8'h05);
            r_std_setconf <= (w_shadow_next[0] == 8'h00) && (w_shadow_next[1] == 8'h09);
            r_std_clrhalt <= (w_shadow_next[0] == 8'h02) && (w_shadow_next[1] == 8'h01)
                             && (w_shadow_next[2] == 8'h00) && (w_shadow_next[3] == 8'h00);
        end
    end

    assign std_setaddr = r_std_setaddr;
    assign std_setconf = r_std_setconf;
    assign std_clrhalt = r_std_clrhalt;
`else
    assign std_setaddr = 1'b0;
    assign std_setconf = 1'b0;
    assign std_clrhalt = 1'b0;
`endif

    assign bm_request_type = r_bm;
    assign b_request       = r_breq;
    assign w_value         = r_wval;
    assign w_index         = r_widx;
    assign w_length        = r_wlen;
    assign setup_valid     = r_setup_valid;
    assign setup_err       = r_setup_err;

endmodule
